// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared types and constants for the chunked multi-cycle adder/subtractor.
//   state_e : controller states (IDLE, RUN, DONE)
//   OP_ADD  : sub input value selecting a + b
//   OP_SUB  : sub input value selecting a - b (a + ~b + 1)
// -----------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_seq_fa_chunk.sv
// -----------------------------------------------------------------------------
// fa_chunk
// Combinational ripple of CHUNK full adders used once per cycle by addsub_seq.
// Ports:
//   a_i, b_i  : CHUNK-bit operand slices (bit 0 = least significant)
//   cin_i     : carry into bit 0
//   sum_o     : CHUNK-bit sum slice
//   cout_o    : carry out of the slice MSB
//   cmsb_o    : carry into the slice MSB (used for signed overflow)
// -----------------------------------------------------------------------------
module fa_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    // c[i] is the carry into bit i; c[CHUNK] leaves the slice
    logic [CHUNK:0] c;

    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = cin_i;
        for (int i = 0; i < CHUNK; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = c[CHUNK];
    assign cmsb_o = c[CHUNK-1];

endmodule

// File: rtl/addsub_seq.sv
// -----------------------------------------------------------------------------
// addsub_seq
// Multi-cycle adder/subtractor: CHUNK bits per cycle, least significant chunk
// first, with a registered carry between chunks and valid/ready on both sides.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | in_ready=1, waiting for in_valid; operands latched on accept
//   RUN   | one chunk summed per cycle, NUM_CHUNKS cycles
//   DONE  | out_valid=1, result and flags held until out_ready
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready only in IDLE)
//   a, b, sub           : operands (index 0 = MSB), 0 add / 1 subtract
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   sum                 : result modulo 2^WIDTH (index 0 = MSB)
//   cout, ovf, zero     : carry out of MSB, signed overflow, sum == 0
// -----------------------------------------------------------------------------
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int CW         = $clog2(NUM_CHUNKS + 1);
    localparam logic [CW-1:0]    LAST_CNT = CW'(NUM_CHUNKS - 1);
    localparam logic [WIDTH-1:0] CMASK    = WIDTH'({CHUNK{1'b1}});

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("addsub_seq: CHUNK (%0d) must divide WIDTH (%0d)", CHUNK, WIDTH);
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Ports are declared MSB-at-index-0; internally everything is [WIDTH-1:0]
    // so that bit i has weight 2^i. Whole-vector assignment preserves value.
    logic [WIDTH-1:0] a_n, b_n;
    assign a_n = a;
    assign b_n = b;

    int unsigned      base;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CHUNK-1:0] fa_sum;
    logic             fa_cout, fa_cmsb;

    always_comb begin
        base = int'(cnt_q) * CHUNK;
        a_sh = a_q >> base;
        b_sh = b_q >> base;
    end

    fa_chunk #(.CHUNK(CHUNK)) u_fa (
        .a_i    (a_sh[CHUNK-1:0]),
        .b_i    (b_sh[CHUNK-1:0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout),
        .cmsb_o (fa_cmsb)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    // Subtraction is folded into the operand: a + ~b + 1
                    a_d     = a_n;
                    b_d     = b_n ^ {WIDTH{sub == OP_SUB}};
                    carry_d = (sub == OP_SUB);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = (res_q & ~(CMASK << base)) | (WIDTH'(fa_sum) << base);
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    // Final chunk holds the MSB, so its carries give the flags
                    cnt_d   = '0;
                    cout_d  = fa_cout;
                    ovf_d   = fa_cout ^ fa_cmsb;
                    zero_d  = (res_d == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = res_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
